// File: rtl/demux_8bus_1_4_buffered.sv
// 1:4 bus demux with a small FIFO per output channel so one stalled consumer
// never blocks traffic headed to the other three.

module demux_8bus_1_4_buffered_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [WIDTH-1:0]            last;
  logic                        pop;

  assign valid = (level != '0);
  assign full  = (level == LW'(DEPTH));
  assign pop   = valid & pop_ready;
  // An empty channel shows the last beat written rather than a stale slot.
  assign data  = valid ? mem[rd_ptr] : last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
        last        <= push_data;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

module demux_8bus_1_4_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [1:0]                     in_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [4*WIDTH-1:0]             out_data,
  output logic [3:0]                     out_valid,
  input  logic [3:0]                     out_ready,
  output logic [4*($clog2(DEPTH)+1)-1:0] out_level
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [3:0] full;

  // Ready reflects only the target channel; a same-cycle pop never frees space.
  assign in_ready = ~full[in_sel];

  for (genvar k = 0; k < 4; k++) begin : g_chan
    logic push;
    assign push = in_valid & in_ready & (in_sel == 2'(k));

    demux_8bus_1_4_buffered_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop_ready (out_ready[k]),
      .data      (out_data[k*WIDTH +: WIDTH]),
      .valid     (out_valid[k]),
      .full      (full[k]),
      .level     (out_level[k*LW +: LW])
    );
  end
endmodule

// File: tb/tb_demux_8bus_1_4_buffered.sv
// Directed bench for the buffered 1:4 demux: vector table plus multi-cycle
// sequences for reset, streaming wrap and reset during traffic.

module tb_demux_8bus_1_4_buffered;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_level;

  int n_chk  = 0;
  int n_fail = 0;

  demux_8bus_1_4_buffered #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_level (out_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer must hold sel/data while a beat is offered but not accepted.
  logic       pend;
  logic [1:0] pend_sel;
  logic [7:0] pend_data;
  always @(negedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else begin
      if (pend && in_valid) begin
        n_chk++;
        if (in_sel !== pend_sel || in_data !== pend_data) begin
          n_fail++;
          $display("FAIL producer_hold: got %h/%h expected %h/%h", in_sel, in_data, pend_sel, pend_data);
        end
      end
      pend      <= in_valid && !in_ready;
      pend_sel  <= in_sel;
      pend_data <= in_data;
    end
  end

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic        vld;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  ov;
    logic [31:0] od;
    logic [7:0]  lvl;
  } vec_t;

  vec_t vt[16];

  initial begin
    // routing, one beat per channel, all consumers ready
    vt[0]  = '{2'd0, 8'h01, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h0000_0001, 8'h01};
    vt[1]  = '{2'd1, 8'h02, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0000_0201, 8'h04};
    vt[2]  = '{2'd2, 8'h03, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h0003_0201, 8'h10};
    vt[3]  = '{2'd3, 8'h04, 1'b1, 4'b1111, 1'b1, 4'b1000, 32'h0403_0201, 8'h40};
    vt[4]  = '{2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0403_0201, 8'h00};
    // backpressure on channel 1
    vt[5]  = '{2'd1, 8'hA1, 1'b1, 4'b1101, 1'b1, 4'b0010, 32'h0403_A101, 8'h04};
    vt[6]  = '{2'd1, 8'hA2, 1'b1, 4'b1101, 1'b1, 4'b0010, 32'h0403_A101, 8'h08};
    vt[7]  = '{2'd1, 8'hA3, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'h0403_A101, 8'h08};
    vt[8]  = '{2'd1, 8'hA3, 1'b0, 4'b1101, 1'b0, 4'b0010, 32'h0403_A101, 8'h08};
    // isolation: channel 2 unaffected by full channel 1
    vt[9]  = '{2'd2, 8'h55, 1'b1, 4'b1101, 1'b1, 4'b0110, 32'h0455_A101, 8'h18};
    // release channel 1: no pass-through, then A3 accepted, drain A1,A2,A3
    vt[10] = '{2'd1, 8'hA3, 1'b1, 4'b1111, 1'b0, 4'b0010, 32'h0455_A201, 8'h04};
    vt[11] = '{2'd1, 8'hA3, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0455_A301, 8'h04};
    vt[12] = '{2'd1, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0455_A301, 8'h00};
    // concurrent push/pop on channel 0
    vt[13] = '{2'd0, 8'h10, 1'b1, 4'b1110, 1'b1, 4'b0001, 32'h0455_A310, 8'h01};
    vt[14] = '{2'd0, 8'h11, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h0455_A311, 8'h01};
    vt[15] = '{2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0455_A311, 8'h00};

    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);

    // async reset with channel 2 holding 0x33
    in_sel = 2'd2; in_data = 8'h33; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'h4);
    chk("pre_rst_data", 32'(out_data[23:16]), 32'h33);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_data", out_data, 32'h0);
    chk("async_rst_level", 32'(out_level), 32'h0);
    chk("async_rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    for (int i = 0; i < 16; i++) begin
      in_sel = vt[i].sel; in_data = vt[i].data; in_valid = vt[i].vld; out_ready = vt[i].ordy;
      #1 chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
      chk($sformatf("v%0d_out_data", i), out_data, vt[i].od);
      chk($sformatf("v%0d_out_level", i), 32'(out_level), 32'(vt[i].lvl));
    end

    // continuous stream through channel 3 across pointer wraps
    out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_sel = 2'd3; in_data = 8'h20 + 8'(i); in_valid = 1'b1;
      #1 chk($sformatf("s%0d_in_ready", i), 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("s%0d_out_valid", i), 32'(out_valid), 32'h8);
      chk($sformatf("s%0d_out_data", i), 32'(out_data[31:24]), 32'h20 + 32'(i));
      chk($sformatf("s%0d_level", i), 32'(out_level[7:6]), 32'h1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_drained", 32'(out_valid), 32'h0);

    // reset while channels 0 and 3 are full and a beat is offered
    out_ready = 4'b0000;
    in_valid = 1'b1;
    in_sel = 2'd0; in_data = 8'hC0; @(posedge clk); #1;
    in_data = 8'hC1;                @(posedge clk); #1;
    in_sel = 2'd3; in_data = 8'hD0; @(posedge clk); #1;
    in_data = 8'hD1;                @(posedge clk); #1;
    in_sel = 2'd0; in_data = 8'h77;
    #1;
    chk("midop_full_ready", 32'(in_ready), 32'h0);
    chk("midop_level", 32'(out_level), 32'h82);
    #2 rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midop_rst_valid", 32'(out_valid), 32'h0);
    chk("midop_rst_data", out_data, 32'h0);
    chk("midop_rst_level", 32'(out_level), 32'h0);
    @(negedge clk);
    rst = 1'b0; out_ready = 4'b1111;
    in_sel = 2'd0; in_data = 8'h99; in_valid = 1'b1;
    #1 chk("midop_release_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("midop_first_valid", 32'(out_valid), 32'h1);
    chk("midop_first_data", 32'(out_data[7:0]), 32'h99);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midop_quiet%0d", i), 32'(out_valid), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/demux_8bus_1_4_buffered.md
Name: demux_8bus_1_4_buffered

Overview:
- Reverse of the team's 8-bit 4:1 bus mux: takes one 8-bit input stream and routes each beat to one of four output channels, chosen by a 2-bit select.
- Each output channel has its own small FIFO, so a stalled consumer on one channel does not block traffic to the other channels.
- Both sides use a valid/ready handshake.
- Sits between a single producer, such as a shared bus or decoder front end, and four independent consumers.

Parameters:
- WIDTH, 8, data width of the input and of each output channel.
- DEPTH, 2, entries per channel FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  2  destination channel; 0 selects a, 1 selects b, 2 selects c, 3 selects d.
- in_valid  input  1  input beat present.
- in_ready  output  1  channel in_sel can accept a beat this cycle.
- out_data  output  4*WIDTH  packed channel heads; channel k occupies [k*WIDTH +: WIDTH].
- out_valid  output  4  channel k FIFO is non-empty.
- out_ready  input  4  consumer k accepts its head this cycle.
- out_level  output  4*(log2(DEPTH)+1)  packed occupancy of each channel FIFO, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all FIFOs empty, all pointers 0, out_valid=0000, out_data=0, out_level=0. in_ready reads 1 while and after rst is asserted.
- Reset mid-operation: in-flight data is discarded, with no partial beats.
- in_ready: combinational, equal to ~full[in_sel]. It depends only on in_sel and the channel state, never on in_valid.
- No pass-through when full: a pop on a full channel does not raise in_ready in that same cycle.
- Push: occurs when in_valid && in_ready at a clk edge. in_data is written at the wr_ptr of channel in_sel, then wr_ptr and level are incremented.
- Producer rule: the producer holds in_data and in_sel stable while in_valid=1 and in_ready=0. The bench checks this rule; the RTL does not enforce it.
- Pop: occurs when out_valid[k] && out_ready[k] at a clk edge. rd_ptr[k] is incremented and level[k] decremented.
- out_ready[k] while out_valid[k]=0 is ignored.
- Latency: a beat pushed at edge N appears on out_valid/out_data of its channel after edge N, i.e. 1 cycle.
- out_data[k]: shows the current head, fed by registered storage plus rd_ptr select. It is held stable while out_valid[k]=1 and out_ready[k]=0.
- Simultaneous push and pop on the same non-full, non-empty channel: both occur, level is unchanged, FIFO order is preserved.
- Push to an empty channel while out_ready is high: the beat is not visible until the next cycle, so no pop happens that cycle.
- All four channels may pop in the same cycle; pops are independent of the push target.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from level, not from pointer compare.
- Ordering: strict FIFO per channel. There is no ordering guarantee across channels.
- No internal FSM beyond the per-channel FIFO state: empty, partial, full.
  - Empty goes to partial on push.
  - Partial goes to full on push without pop when level reaches DEPTH.
  - Full goes to partial on pop.
  - Partial goes to empty on pop without push when level reaches 0.
- No X is propagated from unwritten entries: out_data for an empty channel holds the last written value, or 0 after reset.

Test Plan:
- Reset: assert rst asynchronously between edges with channel 2 holding 0x33. Required: out_valid=0000, out_data=0, out_level=0 immediately, and in_ready=1 after release.
- Routing, with out_ready=1111: push 0x01/sel0, 0x02/sel1, 0x03/sel2, 0x04/sel3 on consecutive cycles. Required: each out_valid[k] pulses exactly one cycle, one cycle after acceptance, with out_data[k] equal to 0x0(k+1).
- Backpressure, with out_ready[1]=0: offer 0xA1, 0xA2, 0xA3 to sel1. Required: 0xA1 and 0xA2 are accepted, level[1]=2, and in_ready=0 while 0xA3 is offered. Then raise out_ready[1]. Required: 0xA1 pops, 0xA3 is accepted the following cycle, and drain order is 0xA1, 0xA2, 0xA3.
- Isolation: with channel 1 full and stalled, offer 0x55/sel2. Required: in_ready=1, and 0x55 appears on channel 2 next cycle while channel 1 is untouched.
- Concurrent push/pop and wrap: with channel 0 holding 0x10, push 0x11 while popping. Required: level stays 1 and the head becomes 0x11. Then stream 0x20..0x27 continuously through channel 3 with out_ready[3]=1. Required: all 8 beats arrive in order across multiple pointer wraps, with no bubbles after the first.
- Reset mid-operation: assert rst while channels 0 and 3 are full and in_valid=1. Required: all state is cleared, and the first beat after release (0x99/sel0) is the only one seen on channel 0.
